bp_me_cce_block_stream_adapter: RTL and testbench
=================================================

// Module: bp_me_cce_block_stream_adapter
// PURPOSE
// - Sits directly upstream of the CCE-to-cache converter: turns block-wide BedRock mem commands
//   (header + full cce block) into the header/data/v/last stream that the converter consumes.
// - Collects the converter's response stream back into block-wide mem responses.
// - Two independent FSMs, one per direction. No reordering: one message in flight per direction.
// PARAMETERS
// - block_width_p   512  cce block width in bits; power of 2, >= data_width_p
// - data_width_p     64  stream beat width in bits; power of 2, >= 64
// - header_width_p  -    width of bp_bedrock_cce_mem_msg_header_s; set from the proc params
// - beats_lp         -    localparam, block_width_p/data_width_p (8 by default)
// - cnt_width_lp     -    localparam, BSG_SAFE_CLOG2(beats_lp)
// PORTS
// - clk_i              in   1    clock
// - reset_n_i          in   1    asynchronous reset, active-low
// - mem_cmd_header_i   in   hdr  block command header (msg_type, size, addr used)
// - mem_cmd_data_i     in   blk  full command block
// - mem_cmd_v_i        in   1    command valid
// - mem_cmd_ready_o    out  1    ready_and; command accepted on v & ready
// - str_cmd_header_o   out  hdr  stream header, constant for all beats of a message
// - str_cmd_data_o     out  dw   beat data
// - str_cmd_v_o        out  1    beat valid
// - str_cmd_last_o     out  1    final beat of message
// - str_cmd_ready_i    in   1    ready_and from converter
// - str_resp_header_i  in   hdr  response stream header
// - str_resp_data_i    in   dw   response beat
// - str_resp_v_i       in   1    beat valid
// - str_resp_last_i    in   1    final beat
// - str_resp_ready_o   out  1    ready_and to converter
// - mem_resp_header_o  out  hdr  assembled response header
// - mem_resp_data_o    out  blk  assembled response block
// - mem_resp_v_o       out  1    response valid
// - mem_resp_yumi_i    in   1    response consumed
// - err_o              out  1    sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset_n_i low, async): cmd FSM IDLE, resp FSM COLLECT, counters 0, held regs 0;
//   mem_cmd_ready_o=1, str_cmd_v_o=0, str_cmd_last_o=0, str_resp_ready_o=1, mem_resp_v_o=0, err_o=0.
//   Reset mid-message discards the partial message; no beat is replayed after release.
// - Beat count N: writes (wr, uc_wr) N = clamp((8<<size)/data_width_p, 1, beats_lp); reads (rd, uc_rd) N=1.
// - Cmd FSM IDLE->SEND on mem_cmd_v_i & mem_cmd_ready_o: latch header, block, N; cnt=0.
// - SEND: str_cmd_v_o=1, data=block[cnt*dw +: dw], last=(cnt==N-1). On str_cmd_ready_i: cnt++;
//   after last beat -> IDLE, unless a new command is accepted in that same cycle (stay SEND, cnt=0).
// - mem_cmd_ready_o = IDLE | (SEND & last & str_cmd_ready_i); back-to-back messages have no bubble.
// - Outputs in SEND are driven from registers only; stable while str_cmd_ready_i is low.
// - Resp FSM COLLECT: str_resp_ready_o=1. First beat latches header. Beat k writes slot k; cnt++.
//   On beat with str_resp_last_i -> HOLD, str_resp_ready_o=0.
// - Single-beat response: beat replicated into every slot. Multi-beat: unwritten slots read 0.
// - HOLD: mem_resp_v_o=1, data/header stable; on mem_resp_yumi_i -> COLLECT, cnt=0, next cycle ready.
// - Counter wrap: cnt is cnt_width_lp bits; a beat beyond beats_lp without last is an overrun.
// - Cmd and resp FSMs are fully independent; simultaneous activity on both sides is legal.
// CONFIGURATION
// - BP_ME_STREAM_ADAPTER_LAST_CHECK_EN defined: resp side checks str_resp_last_i against the
//   count N from the latched header. Early last or overrun sets err_o (sticky until reset);
//   on overrun the FSM forces HOLD at beat beats_lp and later beats wait for the next COLLECT.
// - Undefined: last is trusted, overrun wraps cnt and overwrites slot 0; err_o tied 0.
// TESTING
// - Write size 64B, block 0x..07_06..00 per dword, ready_i=1 -> 8 beats data=k, last on beat 7, 8 cycles.
// - Read size 8B addr 0x8000_0040 -> 1 beat, last=1, header addr unchanged; ready_o high next cycle.
// - Two 64B writes back-to-back, ready_i=1 -> 16 consecutive beats, no idle cycle between messages.
// - ready_i toggled 1/0 during write -> each beat held stable while stalled; order 0..7 preserved.
// - Resp 1 beat 0xDEADBEEF_00000001 -> mem_resp_data_o = 8 copies; hold until yumi, then ready.
// - LAST_CHECK_EN: 64B read resp with last on beat 3 -> err_o=1 and stays 1; without macro err_o=0.

Source files
------------

// File: rtl/bp_me_cce_block_stream_adapter.sv
// bp_me_cce_block_stream_adapter
//   Command path: block-wide BedRock mem command -> header/data/v/last beat stream.
//   Response path: converter beat stream -> block-wide BedRock mem response.
//   One message in flight per direction; the two directions are independent.
//   Optional feature: define BP_ME_STREAM_ADAPTER_LAST_CHECK_EN to check the response
//   last flag against the beat count implied by the response header (sticky err_o).
//   Header fields used: [3:0] msg_type, [46:44] size (log2 bytes); addr sits in [43:4].

module bp_me_cce_block_stream_adapter #(
    parameter int block_width_p  = 512,
    parameter int data_width_p   = 64,
    parameter int header_width_p = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] mem_cmd_header_i,
    input  logic [block_width_p-1:0]  mem_cmd_data_i,
    input  logic                      mem_cmd_v_i,
    output logic                      mem_cmd_ready_o,
    output logic [header_width_p-1:0] str_cmd_header_o,
    output logic [data_width_p-1:0]   str_cmd_data_o,
    output logic                      str_cmd_v_o,
    output logic                      str_cmd_last_o,
    input  logic                      str_cmd_ready_i,
    input  logic [header_width_p-1:0] str_resp_header_i,
    input  logic [data_width_p-1:0]   str_resp_data_i,
    input  logic                      str_resp_v_i,
    input  logic                      str_resp_last_i,
    output logic                      str_resp_ready_o,
    output logic [header_width_p-1:0] mem_resp_header_o,
    output logic [block_width_p-1:0]  mem_resp_data_o,
    output logic                      mem_resp_v_o,
    input  logic                      mem_resp_yumi_i,
    output logic                      err_o
);
    localparam int beats_lp     = block_width_p / data_width_p;
    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    typedef enum logic [3:0] {
        e_mem_rd    = 4'h0,
        e_mem_wr    = 4'h1,
        e_mem_uc_rd = 4'h2,
        e_mem_uc_wr = 4'h3
    } mem_type_e;

    typedef enum logic {CMD_IDLE, CMD_SEND}     cmd_state_e;
    typedef enum logic {RESP_COLLECT, RESP_HOLD} resp_state_e;

    // Index of the final beat of a message. Only the data-carrying direction
    // (writes on the command side, reads on the response side) uses more than one beat.
    function automatic logic [cnt_width_lp-1:0] last_idx_f(input logic [3:0] msg_type,
                                                           input logic [2:0] size,
                                                           input logic       data_on_wr);
        int   n;
        logic is_wr;
        logic is_rd;
        is_wr = (msg_type == e_mem_wr) || (msg_type == e_mem_uc_wr);
        is_rd = (msg_type == e_mem_rd) || (msg_type == e_mem_uc_rd);
        n     = 1;
        if ((data_on_wr && is_wr) || (!data_on_wr && is_rd)) begin
            n = (8 << size) / data_width_p;
            if (n < 1)        n = 1;
            if (n > beats_lp) n = beats_lp;
        end
        return cnt_width_lp'(n - 1);
    endfunction

    // ---------------------------------------------------------------- command path
    cmd_state_e                r_cmd_state;
    cmd_state_e                w_cmd_state_nxt;
    logic [header_width_p-1:0] r_cmd_header;
    logic [block_width_p-1:0]  r_cmd_block;
    logic [cnt_width_lp-1:0]   r_cmd_cnt;
    logic [cnt_width_lp-1:0]   r_cmd_last_idx;
    logic                      w_cmd_last;
    logic                      w_cmd_beat;
    logic                      w_cmd_accept;

    assign w_cmd_last       = (r_cmd_state == CMD_SEND) && (r_cmd_cnt == r_cmd_last_idx);
    assign w_cmd_beat       = (r_cmd_state == CMD_SEND) && str_cmd_ready_i;
    assign mem_cmd_ready_o  = (r_cmd_state == CMD_IDLE) || (w_cmd_beat && w_cmd_last);
    assign w_cmd_accept     = mem_cmd_v_i && mem_cmd_ready_o;
    assign str_cmd_v_o      = (r_cmd_state == CMD_SEND);
    assign str_cmd_last_o   = w_cmd_last;
    assign str_cmd_header_o = r_cmd_header;
    assign str_cmd_data_o   = r_cmd_block[data_width_p-1:0];

    // Command FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n_i) r_cmd_state <= CMD_IDLE;
        else            r_cmd_state <= w_cmd_state_nxt;
    end

    // Command FSM next state; a command accepted on the last beat keeps us in SEND.
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_cmd_state_nxt = r_cmd_state;
        case (r_cmd_state)
            CMD_IDLE: if (w_cmd_accept) w_cmd_state_nxt = CMD_SEND;
            CMD_SEND: if (w_cmd_beat && w_cmd_last && !w_cmd_accept) w_cmd_state_nxt = CMD_IDLE;
            default:  w_cmd_state_nxt = CMD_IDLE;
        endcase
    end

    // Command datapath: latch the block, then shift it down one beat per handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: held data registers are reset too, so outputs are defined zeros out of reset.
        if (!reset_n_i) begin
            r_cmd_header   <= '0;
            r_cmd_block    <= '0;
            r_cmd_cnt      <= '0;
            r_cmd_last_idx <= '0;
        end else if (w_cmd_accept) begin
            r_cmd_header   <= mem_cmd_header_i;
            r_cmd_block    <= mem_cmd_data_i;
            r_cmd_cnt      <= '0;
            r_cmd_last_idx <= last_idx_f(mem_cmd_header_i[3:0], mem_cmd_header_i[46:44], 1'b1);
        end else if (w_cmd_beat) begin
            r_cmd_cnt      <= r_cmd_cnt + cnt_width_lp'(1);
            r_cmd_block    <= r_cmd_block >> data_width_p;
        end
    end

    // ---------------------------------------------------------------- response path
    resp_state_e               r_resp_state;
    resp_state_e               w_resp_state_nxt;
    logic [header_width_p-1:0] r_resp_header;
    logic [block_width_p-1:0]  r_resp_data;
    logic [cnt_width_lp-1:0]   r_resp_cnt;
    logic                      r_resp_first;
    logic                      w_resp_beat;
    logic                      w_resp_done;

    assign w_resp_beat       = (r_resp_state == RESP_COLLECT) && str_resp_v_i;
    assign str_resp_ready_o  = (r_resp_state == RESP_COLLECT);
    assign mem_resp_v_o      = (r_resp_state == RESP_HOLD);
    assign mem_resp_header_o = r_resp_header;
    assign mem_resp_data_o   = r_resp_data;

`ifdef BP_ME_STREAM_ADAPTER_LAST_CHECK_EN
    logic [3:0]              w_resp_type;
    logic [2:0]              w_resp_size;
    logic [cnt_width_lp-1:0] w_resp_exp_idx;
    logic                    w_resp_overrun;
    logic                    w_resp_bad;
    logic                    r_err;

    // The first beat's header is not latched yet, so take its fields straight from the port.
    assign w_resp_type    = r_resp_first ? str_resp_header_i[3:0]   : r_resp_header[3:0];
    assign w_resp_size    = r_resp_first ? str_resp_header_i[46:44] : r_resp_header[46:44];
    assign w_resp_exp_idx = last_idx_f(w_resp_type, w_resp_size, 1'b0);
    assign w_resp_overrun = !str_resp_last_i && (r_resp_cnt == cnt_width_lp'(beats_lp - 1));
    assign w_resp_bad     = w_resp_beat &&
                            ((str_resp_last_i && (r_resp_cnt != w_resp_exp_idx)) || w_resp_overrun);
    assign w_resp_done    = w_resp_beat && (str_resp_last_i || w_resp_overrun);
    assign err_o          = r_err;

    // Sticky protocol error: wrong last position or a block-filling beat without last.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)      r_err <= 1'b0;
        else if (w_resp_bad) r_err <= 1'b1;
    end
`else
    assign w_resp_done = w_resp_beat && str_resp_last_i;
    assign err_o       = 1'b0;
`endif

    // Response FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_resp_state <= RESP_COLLECT;
        else            r_resp_state <= w_resp_state_nxt;
    end

    // Response FSM next state: collect until the final beat, hold until consumed.
    always_comb begin
        w_resp_state_nxt = r_resp_state;
        case (r_resp_state)
            RESP_COLLECT: if (w_resp_done)     w_resp_state_nxt = RESP_HOLD;
            RESP_HOLD:    if (mem_resp_yumi_i) w_resp_state_nxt = RESP_COLLECT;
            default:      w_resp_state_nxt = RESP_COLLECT;
        endcase
    end

    // Response datapath: first beat clears (or replicates into) the block, later beats fill slot k.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_resp_header <= '0;
            r_resp_data   <= '0;
            r_resp_cnt    <= '0;
            r_resp_first  <= 1'b1;
        end else if (w_resp_beat) begin
            r_resp_cnt   <= r_resp_cnt + cnt_width_lp'(1);
            r_resp_first <= 1'b0;
            if (r_resp_first) begin
                r_resp_header <= str_resp_header_i;
                if (str_resp_last_i) r_resp_data <= {beats_lp{str_resp_data_i}};
                else                 r_resp_data <= block_width_p'(str_resp_data_i);
            end else begin
                r_resp_data[int'(r_resp_cnt)*data_width_p +: data_width_p] <= str_resp_data_i;
            end
        end else if ((r_resp_state == RESP_HOLD) && mem_resp_yumi_i) begin
            r_resp_cnt   <= '0;
            r_resp_first <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_me_cce_block_stream_adapter.sv
// tb_bp_me_cce_block_stream_adapter
//   Directed bench for the block/stream adapter. Command beats are checked by a
//   negedge monitor against a queue filled when each command is driven; responses
//   are checked against a queue filled when their beats are driven.
//   Expects err_o behaviour according to BP_ME_STREAM_ADAPTER_LAST_CHECK_EN.

module tb_bp_me_cce_block_stream_adapter;
    localparam int BW    = 512;
    localparam int DW    = 64;
    localparam int HW    = 64;
    localparam int BEATS = BW / DW;

    typedef struct {
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [HW-1:0] hdr;
        logic [BW-1:0] blk;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] mem_cmd_header_i;
    logic [BW-1:0] mem_cmd_data_i;
    logic          mem_cmd_v_i;
    logic          mem_cmd_ready_o;
    logic [HW-1:0] str_cmd_header_o;
    logic [DW-1:0] str_cmd_data_o;
    logic          str_cmd_v_o;
    logic          str_cmd_last_o;
    logic          str_cmd_ready_i;
    logic [HW-1:0] str_resp_header_i;
    logic [DW-1:0] str_resp_data_i;
    logic          str_resp_v_i;
    logic          str_resp_last_i;
    logic          str_resp_ready_o;
    logic [HW-1:0] mem_resp_header_o;
    logic [BW-1:0] mem_resp_data_o;
    logic          mem_resp_v_o;
    logic          mem_resp_yumi_i;
    logic          err_o;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t cmd_q[$];
    resp_t resp_q[$];
    logic  prev_stalled = 1'b0;

    bp_me_cce_block_stream_adapter #(
        .block_width_p (BW),
        .data_width_p  (DW),
        .header_width_p(HW)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .mem_cmd_header_i (mem_cmd_header_i),
        .mem_cmd_data_i   (mem_cmd_data_i),
        .mem_cmd_v_i      (mem_cmd_v_i),
        .mem_cmd_ready_o  (mem_cmd_ready_o),
        .str_cmd_header_o (str_cmd_header_o),
        .str_cmd_data_o   (str_cmd_data_o),
        .str_cmd_v_o      (str_cmd_v_o),
        .str_cmd_last_o   (str_cmd_last_o),
        .str_cmd_ready_i  (str_cmd_ready_i),
        .str_resp_header_i(str_resp_header_i),
        .str_resp_data_i  (str_resp_data_i),
        .str_resp_v_i     (str_resp_v_i),
        .str_resp_last_i  (str_resp_last_i),
        .str_resp_ready_o (str_resp_ready_o),
        .mem_resp_header_o(mem_resp_header_o),
        .mem_resp_data_o  (mem_resp_data_o),
        .mem_resp_v_o     (mem_resp_v_o),
        .mem_resp_yumi_i  (mem_resp_yumi_i),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                             input logic [39:0] addr);
        return {17'b0, sz, addr, t};
    endfunction

    // Beats per message: size-derived for the data-carrying type, otherwise one.
    function automatic int n_beats(input logic [3:0] t, input logic [2:0] sz, input bit data_on_wr);
        int n;
        bit carries;
        carries = data_on_wr ? (t == 4'h1 || t == 4'h3) : (t == 4'h0 || t == 4'h2);
        if (!carries) return 1;
        n = (8 << sz) / DW;
        if (n < 1)     n = 1;
        if (n > BEATS) n = BEATS;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command (call at posedge+1); expected beats are queued up front.
    task automatic send_cmd(input logic [HW-1:0] hdr, input logic [BW-1:0] blk);
        int  n;
        bit  ok;
        beat_t b;
        n = n_beats(hdr[3:0], hdr[46:44], 1'b1);
        for (int k = 0; k < n; k++) begin
            b.hdr  = hdr;
            b.data = blk[k*DW +: DW];
            b.last = (k == n - 1);
            cmd_q.push_back(b);
        end
        mem_cmd_header_i = hdr;
        mem_cmd_data_i   = blk;
        mem_cmd_v_i      = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = mem_cmd_ready_o;
        end
        if (!ok) check("cmd_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        mem_cmd_v_i = 1'b0;
    endtask

    // Count consecutive cycles of str_cmd_v_o starting at its first assertion.
    task automatic count_stream(output int n);
        n = 0;
        for (int i = 0; i < 50 && !str_cmd_v_o; i++) @(negedge clk);
        while (str_cmd_v_o && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_resp_beat(input logic [HW-1:0] hdr, input logic [DW-1:0] d, input logic last);
        bit ok;
        str_resp_header_i = hdr;
        str_resp_data_i   = d;
        str_resp_last_i   = last;
        str_resp_v_i      = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = str_resp_ready_o;
        end
        if (!ok) check("resp_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        str_resp_v_i    = 1'b0;
        str_resp_last_i = 1'b0;
    endtask

    // Wait for the assembled response, compare it, check hold behaviour, then consume it.
    task automatic collect_resp(input string tag);
        bit    seen;
        resp_t e;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mem_resp_v_o;
        end
        check({tag, "_v"}, seen, 1'b1);
        if (resp_q.size() == 0) begin
            check({tag, "_queued"}, resp_q.size(), 1);
        end else begin
            e = resp_q.pop_front();
            check({tag, "_hdr"}, mem_resp_header_o, e.hdr);
            check({tag, "_data"}, mem_resp_data_o, e.blk);
            check({tag, "_ready_low"}, str_resp_ready_o, 1'b0);
            repeat (2) begin
                @(negedge clk);
                check({tag, "_hold_v"}, mem_resp_v_o, 1'b1);
                check({tag, "_hold_data"}, mem_resp_data_o, e.blk);
            end
        end
        step();
        mem_resp_yumi_i = 1'b1;
        step();
        mem_resp_yumi_i = 1'b0;
        @(negedge clk);
        check({tag, "_v_after_yumi"}, mem_resp_v_o, 1'b0);
        check({tag, "_ready_after_yumi"}, str_resp_ready_o, 1'b1);
    endtask

    // Command stream monitor: every valid beat must match the queue head; stalls hold valid.
    always @(negedge clk) begin
        if (prev_stalled) check("stall_hold_v", str_cmd_v_o, 1'b1);
        if (rst_n && str_cmd_v_o) begin
            check("cmd_beat_expected", cmd_q.size() != 0, 1'b1);
            if (cmd_q.size() != 0) begin
                check("cmd_data", str_cmd_data_o, cmd_q[0].data);
                check("cmd_last", str_cmd_last_o, cmd_q[0].last);
                check("cmd_hdr", str_cmd_header_o, cmd_q[0].hdr);
                if (str_cmd_ready_i) void'(cmd_q.pop_front());
            end
        end
        prev_stalled <= rst_n && str_cmd_v_o && !str_cmd_ready_i;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int            n;
        logic [BW-1:0] blk;
        logic [BW-1:0] blk2;
        logic [DW-1:0] d [BEATS];
        logic          exp_err;
        resp_t         r;

        rst_n             = 1'b0;
        mem_cmd_header_i  = '0;
        mem_cmd_data_i    = '0;
        mem_cmd_v_i       = 1'b0;
        str_cmd_ready_i   = 1'b1;
        str_resp_header_i = '0;
        str_resp_data_i   = '0;
        str_resp_v_i      = 1'b0;
        str_resp_last_i   = 1'b0;
        mem_resp_yumi_i   = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", mem_cmd_ready_o, 1'b1);
        check("rst_str_cmd_v", str_cmd_v_o, 1'b0);
        check("rst_str_cmd_last", str_cmd_last_o, 1'b0);
        check("rst_resp_ready", str_resp_ready_o, 1'b1);
        check("rst_resp_v", mem_resp_v_o, 1'b0);
        check("rst_resp_data", mem_resp_data_o, '0);
        check("rst_err", err_o, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // 64B write: 8 beats, data = beat index, last on beat 7, 8 consecutive cycles.
        blk = '0;
        for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = 64'(k);
        fork
            send_cmd(mk_hdr(4'h1, 3'd6, 40'h00_0000_1000), blk);
            count_stream(n);
        join
        check("wr64_cycles", n, 8);
        check("wr64_drained", cmd_q.size(), 0);

        // 8B read: single beat with last, header unchanged, ready again right after.
        step();
        fork
            send_cmd(mk_hdr(4'h0, 3'd3, 40'h00_8000_0040), {448'b0, 64'hCAFE_F00D_1234_5678});
            count_stream(n);
        join
        check("rd8_cycles", n, 1);
        check("rd8_ready_after", mem_cmd_ready_o, 1'b1);
        check("rd8_drained", cmd_q.size(), 0);

        // Two back-to-back 64B writes: 16 beats with no idle cycle.
        step();
        blk2 = '0;
        for (int k = 0; k < BEATS; k++) blk2[k*DW +: DW] = {32'hB2B0_0000, 32'(k)};
        fork
            begin
                send_cmd(mk_hdr(4'h1, 3'd6, 40'h00_0000_2000), blk);
                send_cmd(mk_hdr(4'h3, 3'd6, 40'h00_0000_3000), blk2);
            end
            count_stream(n);
        join
        check("b2b_cycles", n, 16);
        check("b2b_drained", cmd_q.size(), 0);

        // 64B write with ready toggling every cycle: beats held stable, order kept.
        step();
        for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = {$urandom, $urandom};
        fork
            send_cmd(mk_hdr(4'h1, 3'd6, 40'h00_0000_4000), blk);
            for (int i = 0; i < 30; i++) begin
                step();
                str_cmd_ready_i = ~str_cmd_ready_i;
            end
        join
        step();
        str_cmd_ready_i = 1'b1;
        for (int i = 0; i < 40 && cmd_q.size() != 0; i++) @(negedge clk);
        check("stall_drained", cmd_q.size(), 0);

        // Single-beat response replicated into every slot.
        step();
        r.hdr = mk_hdr(4'h0, 3'd3, 40'h00_8000_0040);
        r.blk = {BEATS{64'hDEAD_BEEF_0000_0001}};
        resp_q.push_back(r);
        send_resp_beat(r.hdr, 64'hDEAD_BEEF_0000_0001, 1'b1);
        collect_resp("resp1");

        // 64B read response of 8 beats, concurrent with a 64B write on the command side.
        step();
        r.hdr = mk_hdr(4'h0, 3'd6, 40'h00_0000_5000);
        r.blk = '0;
        for (int k = 0; k < BEATS; k++) begin
            d[k] = {$urandom, $urandom};
            r.blk[k*DW +: DW] = d[k];
        end
        resp_q.push_back(r);
        for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = 64'(k + 16);
        fork
            send_cmd(mk_hdr(4'h1, 3'd6, 40'h00_0000_6000), blk);
            for (int k = 0; k < BEATS; k++) send_resp_beat(r.hdr, d[k], k == BEATS - 1);
        join
        collect_resp("resp8");
        for (int i = 0; i < 20 && cmd_q.size() != 0; i++) @(negedge clk);
        check("concurrent_cmd_drained", cmd_q.size(), 0);

        // 16B read response of 2 beats: unwritten slots read zero.
        step();
        r.hdr = mk_hdr(4'h2, 3'd4, 40'h00_0000_7000);
        r.blk = '0;
        for (int k = 0; k < 2; k++) begin
            d[k] = {$urandom, $urandom};
            r.blk[k*DW +: DW] = d[k];
        end
        resp_q.push_back(r);
        send_resp_beat(r.hdr, d[0], 1'b0);
        send_resp_beat(r.hdr, d[1], 1'b1);
        collect_resp("resp2");
        check("err_clean", err_o, 1'b0);

        // 64B read response ending early on beat 3.
        step();
`ifdef BP_ME_STREAM_ADAPTER_LAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        r.hdr = mk_hdr(4'h0, 3'd6, 40'h00_0000_8000);
        r.blk = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = {$urandom, $urandom};
            r.blk[k*DW +: DW] = d[k];
        end
        resp_q.push_back(r);
        for (int k = 0; k < 4; k++) send_resp_beat(r.hdr, d[k], k == 3);
        collect_resp("resp_early");
        check("early_last_err", err_o, exp_err);
        repeat (3) step();
        @(negedge clk);
        check("early_last_err_sticky", err_o, exp_err);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
